inst_uncached_fetch_bridge: RTL and testbench

//  Responder side of the fetch stage's uncached instruction port: turns a fetch request (PC,

---
 rtl/cpu_bus_pkg.sv | 8 +
 rtl/inst_uncached_fetch_bridge.sv | 98 +++++++++
 tb/tb_inst_uncached_fetch_bridge.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared AXI encodings and uncached fetch FSM state type
package cpu_bus_pkg;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] ARPROT_INST    = 3'b100;
  typedef enum logic [2:0] {IDLE, AR, R, HOLD, DRAIN} ifetch_ucst_e;
endpackage

// File: rtl/inst_uncached_fetch_bridge.sv
// inst_uncached_fetch_bridge: single-outstanding uncached instruction fetch over one AXI4 read beat
module inst_uncached_fetch_bridge
  import cpu_bus_pkg::*;
#(
  parameter int AXI_ID = 0,
  parameter int ID_W   = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req,
  input  logic [31:0]     reqAddr,
  input  logic            flush,
  input  logic            accept,
  output logic            instSramValid,
  output logic [31:0]     instSramData,
  output logic            instSramErr,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [3:0]      arcache,
  output logic [2:0]      arprot,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready
);
  ifetch_ucst_e state;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        err_q;
  logic        kill_q;
  logic        unused_rid;
  assign unused_rid    = ^rid;
  assign arid          = ID_W'(AXI_ID);
  assign araddr        = addr_q;
  assign arlen         = 8'd0;
  assign arsize        = AXI_SIZE_4B;
  assign arburst       = AXI_BURST_INCR;
  assign arcache       = 4'b0000;
  assign arprot        = ARPROT_INST;
  assign instSramData  = data_q;
  assign instSramErr   = err_q;
  // the held word is only offered while the fetch stage still asks for that exact address
  assign instSramValid = (state == HOLD) && (reqAddr == addr_q) && !flush;
  // fetch FSM: AR handshake, R beat capture, hold for consumer, drain killed reads
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state   <= IDLE;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (req && !flush) begin
            addr_q  <= reqAddr;
            arvalid <= 1'b1;
            state   <= AR;
          end
        AR: begin
          if (flush) kill_q <= 1'b1;
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= (kill_q || flush) ? DRAIN : R;
          end
        end
        R:
          if (rvalid && rlast) begin
            rready <= 1'b0;
            if (flush) state <= IDLE;
            else begin
              data_q <= rdata;
              err_q  <= (rresp != AXI_RESP_OKAY);
              state  <= HOLD;
            end
          end else if (flush) state <= DRAIN;
        DRAIN:
          if (rvalid && rlast) begin
            rready <= 1'b0;
            kill_q <= 1'b0;
            state  <= IDLE;
          end
        HOLD:
          if (accept || flush || (reqAddr != addr_q)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_inst_uncached_fetch_bridge.sv
// tb_inst_uncached_fetch_bridge: directed scenarios plus randomized traffic against a transaction-level model
module tb_inst_uncached_fetch_bridge;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0, flush = 1'b0, accept = 1'b0;
  logic [31:0] reqAddr = 32'd0;
  logic        instSramValid, instSramErr;
  logic [31:0] instSramData;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic        arvalid, rready;
  logic        arready = 1'b0;
  logic [3:0]  rid = 4'd0;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'd0;
  logic        rlast = 1'b1, rvalid = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // model: address phase pending, data phase pending, killed, word held
  bit          m_ar, m_r, m_kill, m_have, m_err;
  logic [31:0] m_addr, m_data;
  bit          resp_pending;
  int          resp_delay;

  inst_uncached_fetch_bridge #(.AXI_ID(0), .ID_W(4)) dut (
    .clk(clk), .resetn(resetn), .req(req), .reqAddr(reqAddr), .flush(flush), .accept(accept),
    .instSramValid(instSramValid), .instSramData(instSramData), .instSramErr(instSramErr),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ar = 0; m_r = 0; m_kill = 0; m_have = 0; m_err = 0;
    m_addr = 32'd0; m_data = 32'd0;
    resp_pending = 0; resp_delay = 0;
  endtask

  task automatic compare();
    bit exp_valid;
    exp_valid = m_have && (reqAddr == m_addr) && !flush;
    chk("arvalid", arvalid, m_ar);
    chk("rready", rready, m_r);
    chk("instSramValid", instSramValid, exp_valid);
    if (m_ar) chk("araddr", araddr, m_addr);
    if (exp_valid) begin
      chk("instSramData", instSramData, m_data);
      chk("instSramErr", instSramErr, m_err);
    end
  endtask

  task automatic model_update();
    if (m_have) begin
      if (accept || flush || reqAddr != m_addr) m_have = 0;
    end else if (m_ar) begin
      if (flush) m_kill = 1;
      if (arready) begin m_ar = 0; m_r = 1; end
    end else if (m_r) begin
      if (rvalid && rlast) begin
        m_r = 0;
        if (!m_kill && !flush) begin m_have = 1; m_data = rdata; m_err = (rresp != 2'b00); end
        m_kill = 0;
      end else if (flush) m_kill = 1;
    end else if (req && !flush) begin
      m_ar = 1; m_addr = reqAddr;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
  endtask

  task automatic adv();
    @(posedge clk);
    if (resetn) begin
      if (m_ar && arready) begin resp_pending = 1; resp_delay = $urandom_range(0, 3); end
      else if (m_r && rvalid && rlast) resp_pending = 0;
      else if (resp_pending && resp_delay > 0) resp_delay--;
      model_update();
    end
    #1;
  endtask

  task automatic fetch_to_hold(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rs);
    req = 1; reqAddr = a; arready = 1; rvalid = 0; flush = 0; accept = 0;
    tick(); adv();
    chk("lat_arvalid", arvalid, 1'b1);
    chk("lat_araddr", araddr, a);
    tick(); adv();
    arready = 0; rvalid = 1; rlast = 1; rdata = d; rresp = rs;
    chk("lat_rready", rready, 1'b1);
    tick(); adv();
    rvalid = 0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_valid", instSramValid, 1'b0);
    chk("rst_data", instSramData, 32'd0);
    chk("rst_err", instSramErr, 1'b0);
    chk("const_ar", {arid, arlen, arsize, arburst, arcache, arprot}, {4'd0, 8'd0, 3'b010, 2'b01, 4'b0000, 3'b100});
    resetn = 1;
    @(posedge clk); #1;

    // basic fetch, valid on cycle 3
    fetch_to_hold(32'hBFC00000, 32'h3C08BFC0, 2'b00);
    chk("t1_valid", instSramValid, 1'b1);
    chk("t1_data", instSramData, 32'h3C08BFC0);
    chk("t1_err", instSramErr, 1'b0);
    accept = 1; tick(); adv();
    accept = 0; req = 0;
    chk("t1_after_accept", instSramValid, 1'b0);
    tick(); adv();
    chk("t1_idle", arvalid, 1'b0);

    // arready stalled, flush mid address phase -> drained silently
    req = 1; reqAddr = 32'hBFC00010; arready = 0;
    tick(); adv();
    for (int i = 0; i < 5; i++) begin
      chk("t2_arvalid_stable", arvalid, 1'b1);
      chk("t2_araddr_stable", araddr, 32'hBFC00010);
      flush = (i == 1);
      tick(); adv();
    end
    flush = 0; arready = 1;
    tick(); adv();
    arready = 0; req = 0;
    chk("t2_drain_rready", rready, 1'b1);
    rvalid = 1; rdata = 32'hDEADBEEF;
    tick(); adv();
    rvalid = 0;
    chk("t2_no_valid", instSramValid, 1'b0);
    chk("t2_rready_low", rready, 1'b0);
    tick(); adv();

    // flush coincident with the R beat
    req = 1; reqAddr = 32'hBFC00014; arready = 1;
    tick(); adv();
    tick(); adv();
    arready = 0; rvalid = 1; rdata = 32'h11112222; rresp = 0; flush = 1;
    tick(); adv();
    rvalid = 0; flush = 0; req = 0;
    chk("t3_valid", instSramValid, 1'b0);
    chk("t3_rready", rready, 1'b0);
    chk("t3_arvalid", arvalid, 1'b0);
    tick(); adv();

    // slave error response
    fetch_to_hold(32'hBFC00004, 32'h12345678, 2'b10);
    chk("t4_valid", instSramValid, 1'b1);
    chk("t4_err", instSramErr, 1'b1);
    accept = 1; tick(); adv();
    accept = 0; req = 0;
    tick(); adv();
    chk("t4_idle_ar", arvalid, 1'b0);
    chk("t4_idle_r", rready, 1'b0);

    // hold without accept, then stale address
    fetch_to_hold(32'hBFC00004, 32'hA5A55A5A, 2'b00);
    for (int i = 0; i < 4; i++) begin
      chk("t5_hold_valid", instSramValid, 1'b1);
      chk("t5_hold_data", instSramData, 32'hA5A55A5A);
      tick(); adv();
    end
    reqAddr = 32'hBFC00008; #1;
    chk("t5_stale_drop", instSramValid, 1'b0);
    tick(); adv();
    chk("t5_idle", arvalid, 1'b0);
    tick(); adv();
    chk("t5_reissue", arvalid, 1'b1);
    chk("t5_reissue_addr", araddr, 32'hBFC00008);
    arready = 1; tick(); adv();
    arready = 0; rvalid = 1; rdata = 32'h0BADF00D;
    tick(); adv();
    rvalid = 0;
    chk("t5_new_data", instSramData, 32'h0BADF00D);
    accept = 1; tick(); adv();
    accept = 0; req = 0; tick(); adv();

    // async reset during data phase
    req = 1; reqAddr = 32'hBFC00000; arready = 1;
    tick(); adv();
    tick(); adv();
    arready = 0;
    chk("t6_in_r", rready, 1'b1);
    #2 resetn = 0;
    #1;
    chk("t6_rst_arvalid", arvalid, 1'b0);
    chk("t6_rst_rready", rready, 1'b0);
    chk("t6_rst_valid", instSramValid, 1'b0);
    chk("t6_rst_data", instSramData, 32'd0);
    chk("t6_rst_err", instSramErr, 1'b0);
    chk("t6_rst_araddr", araddr, 32'd0);
    model_reset();
    req = 1; reqAddr = 32'hBFC00018;
    @(negedge clk); resetn = 1;
    @(posedge clk); #1;
    chk("t6_fresh_ar", arvalid, 1'b1);
    chk("t6_fresh_addr", araddr, 32'hBFC00018);
    m_ar = 1; m_addr = 32'hBFC00018;
    arready = 1; tick(); adv();
    arready = 0; rvalid = 1; rdata = 32'h24020001; rresp = 0;
    tick(); adv();
    rvalid = 0;
    chk("t6_valid", instSramValid, 1'b1);
    chk("t6_data", instSramData, 32'h24020001);
    accept = 1; tick(); adv();
    accept = 0; req = 0; tick(); adv(); tick(); adv();

    // randomized traffic
    resp_pending = 0;
    for (int n = 0; n < 4000; n++) begin
      arready = ($urandom_range(0, 2) != 0);
      rvalid  = resp_pending && (resp_delay == 0);
      rlast   = 1;
      rdata   = $urandom;
      rresp   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rid     = 4'($urandom_range(0, 15));
      req     = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 7) == 0) reqAddr = 32'hBFC00000 + 32'($urandom_range(0, 3) * 4);
      flush   = ($urandom_range(0, 19) == 0);
      accept  = ($urandom_range(0, 2) == 0);
      tick(); adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
